instruction_cache_dm: RTL and testbench

INSTRUCTION_CACHE_DM -- requirements
Module: instruction_cache_dm

---
 rtl/instruction_cache_dm.sv | 165 ++++++++++++++++
 tb/tb_instruction_cache_dm.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_cache_dm.sv
// Direct-mapped instruction cache: one-cycle hits, line refill from a word-wide
// backing memory, with abort and deferred-flush handling.
module instruction_cache_dm #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int NUM_LINES      = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [ADDRESS_WIDTH-1:0]             PC_in,
    input  logic                                 Rd_en,
    input  logic                                 Abort,
    input  logic                                 Flush,
    output logic [WORDS_PER_LINE*DATA_WIDTH-1:0] Dout,
    output logic                                 Dout_valid,
    output logic                                 Busy,
    output logic                                 mem_req,
    output logic [ADDRESS_WIDTH-1:0]             mem_addr,
    input  logic                                 mem_ready,
    input  logic [DATA_WIDTH-1:0]                mem_data
);
    // state     | meaning
    // S_IDLE    | accepting fetches, hits answered next cycle
    // S_REFILL  | fetching line words from memory, one beat per mem_ready
    // S_RESPOND | one-cycle delivery of the refilled line

    localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
    localparam int WORD_OFF       = $clog2(BYTES_PER_WORD);
    localparam int OFF            = $clog2(WORDS_PER_LINE * BYTES_PER_WORD);
    localparam int IDX_W          = $clog2(NUM_LINES);
    localparam int TAG_W          = ADDRESS_WIDTH - OFF - IDX_W;
    localparam int BEAT_W         = $clog2(WORDS_PER_LINE);
    localparam int LINE_W         = WORDS_PER_LINE * DATA_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] OFF_MASK = ADDRESS_WIDTH'((64'd1 << OFF) - 64'd1);

    typedef enum logic [1:0] {S_IDLE, S_REFILL, S_RESPOND} state_t;

    state_t                   r_state, w_state_nxt;
    logic [BEAT_W-1:0]        r_beat, w_beat_nxt;
    logic [ADDRESS_WIDTH-1:0] r_base, w_base_nxt;
    logic                     r_abort, w_abort_nxt;
    logic                     r_flush_pend, w_flush_nxt;
    logic [NUM_LINES-1:0]     r_valid, w_valid_nxt;
    logic [LINE_W-1:0]        r_dout, w_dout_nxt;
    logic                     r_dv, w_dv_nxt;

    logic [LINE_W-1:0]        r_data [NUM_LINES];
    logic [TAG_W-1:0]         r_tag  [NUM_LINES];

    logic [ADDRESS_WIDTH-1:0] w_pc_base;
    logic [IDX_W-1:0]         w_pc_idx;
    logic [TAG_W-1:0]         w_pc_tag;
    logic [IDX_W-1:0]         w_idx;
    logic                     w_hit;
    logic                     w_last_beat;
    logic                     w_beat_acc;
    logic [LINE_W-1:0]        w_fill_line;

    assign w_pc_base   = PC_in & ~OFF_MASK;
    assign w_pc_idx    = w_pc_base[OFF +: IDX_W];
    assign w_pc_tag    = w_pc_base[ADDRESS_WIDTH-1 -: TAG_W];
    assign w_idx       = r_base[OFF +: IDX_W];
    assign w_hit       = r_valid[w_pc_idx] && (r_tag[w_pc_idx] == w_pc_tag);
    assign w_last_beat = (r_beat == BEAT_W'(WORDS_PER_LINE - 1));
    assign w_beat_acc  = (r_state == S_REFILL) && mem_ready;

    // Line as it will look once the current beat lands, so the response
    // can be registered on the same edge as the last write.
    always_comb begin
        w_fill_line = r_data[w_idx];
        w_fill_line[int'(r_beat)*DATA_WIDTH +: DATA_WIDTH] = mem_data;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_base_nxt  = r_base;
        w_abort_nxt = r_abort;
        w_flush_nxt = r_flush_pend;
        w_valid_nxt = r_valid;
        w_dout_nxt  = '0;
        w_dv_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Flush)
                    w_valid_nxt = '0;
                if (Rd_en && !Abort) begin
                    if (w_hit && !Flush) begin
                        w_dout_nxt = r_data[w_pc_idx];
                        w_dv_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = S_REFILL;
                        w_beat_nxt  = '0;
                        w_base_nxt  = w_pc_base;
                        w_abort_nxt = 1'b0;
                    end
                end
            end
            S_REFILL: begin
                if (Abort)
                    w_abort_nxt = 1'b1;
                if (Flush)
                    w_flush_nxt = 1'b1;
                if (mem_ready) begin
                    w_beat_nxt = r_beat + BEAT_W'(1);
                    if (w_last_beat) begin
                        w_state_nxt        = S_RESPOND;
                        w_valid_nxt[w_idx] = 1'b1;
                        w_dv_nxt           = !(r_abort || Abort);
                        w_dout_nxt         = w_dv_nxt ? w_fill_line : '0;
                    end
                end
            end
            S_RESPOND: begin
                w_state_nxt = S_IDLE;
                w_abort_nxt = 1'b0;
                w_flush_nxt = 1'b0;
                if (r_flush_pend || Flush)
                    w_valid_nxt = '0;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_beat       <= '0;
            r_base       <= '0;
            r_abort      <= 1'b0;
            r_flush_pend <= 1'b0;
            r_valid      <= '0;
            r_dout       <= '0;
            r_dv         <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_beat       <= w_beat_nxt;
            r_base       <= w_base_nxt;
            r_abort      <= w_abort_nxt;
            r_flush_pend <= w_flush_nxt;
            r_valid      <= w_valid_nxt;
            r_dout       <= w_dout_nxt;
            r_dv         <= w_dv_nxt;
        end
    end

    // Storage arrays carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (!rst && w_beat_acc) begin
            r_data[w_idx][int'(r_beat)*DATA_WIDTH +: DATA_WIDTH] <= mem_data;
            if (w_last_beat)
                r_tag[w_idx] <= r_base[ADDRESS_WIDTH-1 -: TAG_W];
        end
    end

    assign Dout       = r_dout;
    assign Dout_valid = r_dv;
    assign Busy       = (r_state != S_IDLE);
    assign mem_req    = (r_state == S_REFILL);
    assign mem_addr   = (r_state == S_REFILL)
                      ? r_base + (ADDRESS_WIDTH'(r_beat) << WORD_OFF)
                      : '0;

endmodule

// File: tb/tb_instruction_cache_dm.sv
// Directed bench for instruction_cache_dm: miss/hit latency, conflict,
// abort, flush and reset-during-refill behaviour against a simple memory.
module tb_instruction_cache_dm;
    logic         clk;
    logic         rst;
    logic [31:0]  PC_in;
    logic         Rd_en;
    logic         Abort;
    logic         Flush;
    logic [127:0] Dout;
    logic         Dout_valid;
    logic         Busy;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ready;
    logic [31:0]  mem_data;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           stall    = 0;
    int           stall_cnt = 0;
    logic [31:0]  q_addr[$];

    instruction_cache_dm #(
        .DATA_WIDTH(32), .ADDRESS_WIDTH(32), .WORDS_PER_LINE(4), .NUM_LINES(16)
    ) dut (
        .clk(clk), .rst(rst), .PC_in(PC_in), .Rd_en(Rd_en), .Abort(Abort),
        .Flush(Flush), .Dout(Dout), .Dout_valid(Dout_valid), .Busy(Busy),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
        .mem_data(mem_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] k;
        k = {30'd0, a[3:2]} + 32'd1;
        if (a[31:4] == 28'h10)
            return 32'h11 * k;
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [127:0] model_line(input logic [31:0] base);
        logic [127:0] l;
        for (int k = 0; k < 4; k++)
            l[k*32 +: 32] = mem_word(base + 32'(k*4));
        return l;
    endfunction

    // Backing memory: mem_ready after `stall` idle cycles per beat.
    always @(negedge clk) begin
        if (mem_req) begin
            if (stall_cnt >= stall) begin
                mem_ready = 1'b1;
                mem_data  = mem_word(mem_addr);
                stall_cnt = 0;
            end else begin
                mem_ready = 1'b0;
                stall_cnt++;
            end
        end else begin
            mem_ready = 1'b0;
            stall_cnt = 0;
        end
    end

    always @(posedge clk)
        if (mem_req && mem_ready && !rst)
            q_addr.push_back(mem_addr);

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fetch(input logic [31:0] pc, input int abort_cyc, input int flush_cyc,
                         output logic got_v, output int lat, output logic [127:0] line);
        int cyc;
        got_v = 1'b0;
        lat   = 0;
        line  = '0;
        q_addr.delete();
        @(negedge clk);
        PC_in = pc;
        Rd_en = 1'b1;
        Abort = (abort_cyc == 0);
        Flush = (flush_cyc == 0);
        cyc = 0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            Rd_en = 1'b0;
            if (Dout_valid) begin
                got_v = 1'b1;
                lat   = cyc;
                line  = Dout;
                break;
            end
            if (!Busy) begin
                lat  = cyc;
                line = Dout;
                break;
            end
            Abort = (cyc == abort_cyc);
            Flush = (cyc == flush_cyc);
        end
        Abort = 1'b0;
        Flush = 1'b0;
        check("fetch_terminates", 128'(cyc < 200), 128'd1);
    endtask

    task automatic expect_miss(input string tag, input logic [31:0] pc, input int flush_cyc);
        logic v; int lat; logic [127:0] line;
        fetch(pc, -1, flush_cyc, v, lat, line);
        check({tag, "_valid"}, 128'(v), 128'd1);
        check({tag, "_latency"}, 128'(lat), 128'd5);
        check({tag, "_line"}, line, model_line(pc & ~32'hF));
        check({tag, "_beats"}, 128'(q_addr.size()), 128'd4);
        for (int k = 0; k < 4; k++)
            if (k < q_addr.size())
                check({tag, "_addr"}, 128'(q_addr[k]), 128'((pc & ~32'hF) + 32'(4*k)));
    endtask

    task automatic expect_hit(input string tag, input logic [31:0] pc);
        logic v; int lat; logic [127:0] line;
        fetch(pc, -1, -1, v, lat, line);
        check({tag, "_valid"}, 128'(v), 128'd1);
        check({tag, "_latency"}, 128'(lat), 128'd1);
        check({tag, "_line"}, line, model_line(pc & ~32'hF));
        check({tag, "_no_mem"}, 128'(q_addr.size()), 128'd0);
    endtask

    initial begin
        logic v; int lat; logic [127:0] line; int guard;
        rst = 1'b1; PC_in = '0; Rd_en = 1'b0; Abort = 1'b0; Flush = 1'b0;
        mem_ready = 1'b0; mem_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 128'(Busy), 128'd0);
        check("rst_dv", 128'(Dout_valid), 128'd0);
        check("rst_dout", Dout, 128'd0);
        check("rst_mem_req", 128'(mem_req), 128'd0);
        check("rst_mem_addr", 128'(mem_addr), 128'd0);
        rst = 1'b0;

        // Cold miss with fixed expected line, then hit on a different offset
        expect_miss("cold", 32'h0000_0100, -1);
        fetch(32'h0000_0108, -1, -1, v, lat, line);
        check("hit_line_const", line, 128'h00000044_00000033_00000022_00000011);
        check("hit_latency", 128'(lat), 128'd1);
        check("hit_no_mem", 128'(q_addr.size()), 128'd0);

        // Same index, different tag evicts the first line
        expect_miss("conflict", 32'h0000_1100, -1);
        expect_miss("refetch_100", 32'h0000_0100, -1);

        // Abort during beat 2 of a slow refill: all beats, no response
        stall = 3;
        fetch(32'h0000_0340, 10, -1, v, lat, line);
        check("abort_no_valid", 128'(v), 128'd0);
        check("abort_dout_zero", line, 128'd0);
        check("abort_beats", 128'(q_addr.size()), 128'd4);
        stall = 0;
        expect_hit("after_abort", 32'h0000_0344);

        // Flush during refill: response delivered, everything invalid after
        expect_miss("flush_fill", 32'h0000_0200, 2);
        expect_miss("flush_other", 32'h0000_0340, -1);
        expect_miss("flush_same", 32'h0000_0200, -1);

        // Flush in IDLE alongside Rd_en on a resident line forces a miss
        expect_miss("idle_flush", 32'h0000_0200, 0);

        // Abort together with Rd_en suppresses the request
        fetch(32'h0000_0200, 0, -1, v, lat, line);
        check("sup_valid", 128'(v), 128'd0);
        check("sup_latency", 128'(lat), 128'd1);
        check("sup_no_mem", 128'(q_addr.size()), 128'd0);
        expect_hit("sup_then_hit", 32'h0000_0200);

        // Reset after two beats of a refill
        q_addr.delete();
        @(negedge clk);
        PC_in = 32'h0000_0440; Rd_en = 1'b1;
        @(negedge clk);
        Rd_en = 1'b0;
        guard = 0;
        while (q_addr.size() < 2 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("rst_mid_reach_beat1", 128'(q_addr.size()), 128'd2);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_busy", 128'(Busy), 128'd0);
        check("rst_mid_mem_req", 128'(mem_req), 128'd0);
        check("rst_mid_dv", 128'(Dout_valid), 128'd0);
        rst = 1'b0;
        expect_miss("after_rst", 32'h0000_0440, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
